// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse-cipher datapath.
// Byte i of a 128-bit block sits at bits [127-8*i -: 8], with columns stored column-major.
package aes_dec_pkg;

    localparam int KEY_IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD0,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    // Source byte for each InvShiftRows output byte: row r is rotated right by r.
    localparam int ISR_SRC [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module aes_inv_mix_column
    import aes_dec_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;

    assign b0 = col[31:24];
    assign b1 = col[23:16];
    assign b2 = col[15:8];
    assign b3 = col[7:0];

    assign mixed = {
        mule(b0) ^ mulb(b1) ^ muld(b2) ^ mul9(b3),
        mul9(b0) ^ mule(b1) ^ mulb(b2) ^ muld(b3),
        muld(b0) ^ mul9(b1) ^ mule(b2) ^ mulb(b3),
        mulb(b0) ^ muld(b1) ^ mul9(b2) ^ mule(b3)
    };

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher round controller with external InvSubBytes and key store.
// Define AES_INV_SPLIT_ROUND_EN to register isb_out and spend two cycles per round.
module aes_inv_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         ct,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [127:0]         round_key,
    output logic [127:0]         isb_in,
    input  logic [127:0]         isb_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         pt,
    output logic                 busy
);

    localparam logic [KEY_IDX_W-1:0] NR_IDX    = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [KEY_IDX_W-1:0] NR_M1_IDX = KEY_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] ONE_IDX   = KEY_IDX_W'(1);

    fsm_t                 fsm_reg;
    fsm_t                 fsm_next;
    logic [KEY_IDX_W-1:0] rnd_reg;
    logic [127:0]         data_reg;
    logic [127:0]         isr_state;
    logic [127:0]         sub_src;
    logic [127:0]         key_added;
    logic [127:0]         mixed;
    logic                 step;

    genvar gi;

`ifdef AES_INV_SPLIT_ROUND_EN
    // Phase A captures isb_out; phase B (step) commits the round from the captured copy.
    logic         phase_reg;
    logic [127:0] sub_reg;

    assign step    = phase_reg;
    assign sub_src = sub_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= 1'b0;
            sub_reg   <= '0;
        end else if (fsm_reg == S_ROUND || fsm_reg == S_FINAL) begin
            phase_reg <= ~phase_reg;
            if (!phase_reg) begin
                sub_reg <= isb_out;
            end
        end else begin
            phase_reg <= 1'b0;
        end
    end
`else
    assign step    = 1'b1;
    assign sub_src = isb_out;
`endif

    generate
        for (gi = 0; gi < 16; gi++) begin : g_isr
            assign isr_state[127-8*gi -: 8] = data_reg[127-8*ISR_SRC[gi] -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            aes_inv_mix_column u_mix (
                .col   (key_added[127-32*gi -: 32]),
                .mixed (mixed[127-32*gi -: 32])
            );
        end
    endgenerate

    assign key_added = sub_src ^ round_key;
    assign isb_in    = isr_state;
    assign pt        = data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg <= S_IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            S_IDLE:  if (in_valid) fsm_next = S_ADD0;
            S_ADD0:  fsm_next = S_ROUND;
            S_ROUND: if (step && rnd_reg == ONE_IDX) fsm_next = S_FINAL;
            S_FINAL: if (step) fsm_next = S_DONE;
            S_DONE:  if (out_ready) fsm_next = S_IDLE;
            default: fsm_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        key_idx   = NR_IDX;
        case (fsm_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_ROUND: key_idx = rnd_reg;
            S_FINAL: key_idx = '0;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_reg  <= NR_IDX;
            data_reg <= '0;
        end else begin
            case (fsm_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        data_reg <= ct;
                        rnd_reg  <= NR_IDX;
                    end
                end
                S_ADD0: begin
                    data_reg <= data_reg ^ round_key;
                    rnd_reg  <= NR_M1_IDX;
                end
                S_ROUND: begin
                    if (step) begin
                        data_reg <= mixed;
                        rnd_reg  <= rnd_reg - ONE_IDX;
                    end
                end
                S_FINAL: begin
                    if (step) begin
                        data_reg <= key_added;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
